// File: rtl/shift_reg_pkg.sv
// ----------------------------------------------------------------------------
// shift_reg_pkg
// Shared constants for the serial-in/serial-out shift register slice.
//   SR_DEPTH_DEFAULT     : default number of stages (= latency in cycles)
//   SR_DEPTH_MAX         : largest supported number of stages
//   SR_RESET_VAL_DEFAULT : default value loaded into every stage on reset
// ----------------------------------------------------------------------------
package shift_reg_pkg;

    localparam int   SR_DEPTH_DEFAULT     = 4;
    localparam int   SR_DEPTH_MAX         = 64;
    localparam logic SR_RESET_VAL_DEFAULT = 1'b0;

    // True when a requested depth lies inside the supported range.
    function automatic logic sr_depth_legal(input int depth);
        return (depth >= 1) && (depth <= SR_DEPTH_MAX);
    endfunction

endpackage : shift_reg_pkg

// File: rtl/shift_reg_nblk_if.sv
// ----------------------------------------------------------------------------
// shift_reg_nblk_if
// Serial data bus for the shift register.
//   sin  : serial data toward the shift register
//   sout : delayed serial data from the shift register
// Modports:
//   master : the stream source/sink (drives sin, observes sout)
//   slave  : the shift register (samples sin, drives sout)
// ----------------------------------------------------------------------------
interface shift_reg_nblk_if;

    logic sin;
    logic sout;

    modport master (
        output sin,
        input  sout
    );

    modport slave (
        input  sin,
        output sout
    );

endinterface : shift_reg_nblk_if

// File: rtl/sr_stage.sv
// ----------------------------------------------------------------------------
// sr_stage
// One bit of storage: a D flip-flop with asynchronous active-high reset to
// RESET_VAL.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   i_d : data captured on the rising edge of clk
//   o_q : stored value, driven straight from the flop
// ----------------------------------------------------------------------------
import shift_reg_pkg::*;

module sr_stage #(
    parameter logic RESET_VAL = SR_RESET_VAL_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    // Storage flop; reset overrides any coincident clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : sr_stage

// File: rtl/shift_reg_nblk.sv
// ----------------------------------------------------------------------------
// shift_reg_nblk
// Serial-in/serial-out delay line of DEPTH flip-flops. A bit sampled on sin
// at a rising edge N is presented on sout after edge N+DEPTH-1.
//   clk      : rising-edge clock for every stage
//   rst      : asynchronous active-high reset, loads RESET_VAL into all stages
//   bus.sin  : serial data in
//   bus.sout : serial data out, the last stage's flop output
// Parameters:
//   DEPTH     : number of stages / latency in cycles, 1..SR_DEPTH_MAX
//   RESET_VAL : value held by every stage while reset is asserted
// ----------------------------------------------------------------------------
import shift_reg_pkg::*;

module shift_reg_nblk #(
    parameter int   DEPTH     = SR_DEPTH_DEFAULT,
    parameter logic RESET_VAL = SR_RESET_VAL_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    shift_reg_nblk_if.slave         bus
);

    // Elaboration-time range check on the stage count.
    if (!sr_depth_legal(DEPTH)) begin : g_depth_check
        $fatal(1, "shift_reg_nblk: DEPTH=%0d outside 1..%0d", DEPTH, SR_DEPTH_MAX);
    end

    // w_chain[0] is the serial input; w_chain[i+1] is the output of stage i.
    logic [DEPTH:0] w_chain;

    assign w_chain[0] = bus.sin;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        sr_stage #(
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .i_d (w_chain[gi]),
            .o_q (w_chain[gi+1])
        );
    end

    // Output comes straight from the last flop; no path from sin.
    assign bus.sout = w_chain[DEPTH];

endmodule : shift_reg_nblk

// File: tb/tb_shift_reg_nblk.sv
// ----------------------------------------------------------------------------
// tb_shift_reg_nblk
// Directed, self-checking bench for shift_reg_nblk at DEPTH=4, 40 ns clock.
// Inputs are driven 1 ns after a rising edge and sout is sampled there too.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_shift_reg_nblk;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    shift_reg_nblk_if bus ();

    shift_reg_nblk #(
        .DEPTH     (4),
        .RESET_VAL (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 40 ns period clock, first rising edge at 20 ns.
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic check(input string tag, input logic expected);
        vectors++;
        assert (bus.sout === expected) else begin
            miscompares++;
            $error("FAIL %s: sout observed %b expected %b at %0t", tag, bus.sout, expected, $time);
        end
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pat_in;
    logic [7:0] pat_exp;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.sin     = 1'b1;

        // Reset clears: sout low immediately and across 3 edges with sin=1.
        #1;
        check("reset_initial", 1'b0);
        for (int i = 0; i < 3; i++) begin
            edge_step();
            check($sformatf("reset_edge%0d", i + 1), 1'b0);
        end

        // Release reset with sin=0: flushing 4 edges shows every stage is 0.
        rst     = 1'b0;
        bus.sin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            edge_step();
            check($sformatf("flush_stage%0d", i), 1'b0);
        end

        // Single pulse: one edge of sin=1 appears only after the 4th edge.
        bus.sin = 1'b1;
        edge_step();
        bus.sin = 1'b0;
        check("pulse_e1", 1'b0);
        edge_step();
        check("pulse_e2", 1'b0);
        edge_step();
        check("pulse_e3", 1'b0);
        edge_step();
        check("pulse_e4", 1'b1);
        edge_step();
        check("pulse_e5", 1'b0);
        edge_step();
        check("pulse_e6", 1'b0);

        // Pattern 1,0,1,1,0,0,0,0: sout reads 1,0,1,1 after edges 4..7.
        pat_in  = 8'b0000_1101;   // bit k is the value for edge k+1
        pat_exp = 8'b0110_1000;   // bit k is sout after edge k+1
        for (int k = 0; k < 8; k++) begin
            bus.sin = pat_in[k];
            edge_step();
            check($sformatf("pattern_e%0d", k + 1), pat_exp[k]);
        end
        bus.sin = 1'b0;

        // Mid-cycle glitch on sin that is low again by the next edge.
        #9;
        bus.sin = 1'b1;
        check("glitch_high", 1'b0);
        #15;
        bus.sin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            edge_step();
            check($sformatf("glitch_e%0d", i + 1), 1'b0);
        end

        // Load 1111, then raise reset 5 ns after an edge.
        bus.sin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_step();
        end
        edge_step();
        check("load_full", 1'b1);
        #4;
        rst = 1'b1;
        #1;
        check("async_reset_drop", 1'b0);
        edge_step();
        check("reset_holds_on_edge", 1'b0);

        // Release reset between edges, shift in a single 1.
        #10;
        rst     = 1'b0;
        bus.sin = 1'b1;
        edge_step();
        bus.sin = 1'b0;
        check("release_e1", 1'b0);
        edge_step();
        check("release_e2", 1'b0);
        edge_step();
        check("release_e3", 1'b0);
        edge_step();
        check("release_e4", 1'b1);
        edge_step();
        check("release_e5", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_shift_reg_nblk
